scanline_packer: RTL and testbench
==================================

SCANLINE_PACKER -- requirements
Module: scanline_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered scanlines (power of 2, 2..16).
REQ-002 SHALL have parameter WIDTH, default 160, meaning pixels per scanline, one bit per pixel.
REQ-003 SHALL have port clk  input  1  the one clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port line_start  input  1  single-cycle pulse marking the start of a new emulated scanline.
REQ-006 SHALL have port pixel_valid  input  1  pixel qualifies this cycle.
REQ-007 SHALL have port pixel  input  1  pixel value.
REQ-008 SHALL have port fifo_ack  input  1  consumer pops the head scanline.
REQ-009 SHALL have port fifo_empty  output  1  high when no complete scanline is buffered.
REQ-010 SHALL have port scanline  output  WIDTH  head scanline; pixel n at bit n.
REQ-011 SHALL have port overflow  output  1  sticky flag; a completed line was dropped.

Function
REQ-012 SHALL hold a pixel index 0..WIDTH; line_start sets it to 0 and clears the assembly register.
REQ-013 SHALL write pixel into assembly bit [index] and increment the index on each pixel_valid while index < WIDTH.
REQ-014 SHALL ignore pixel_valid while index == WIDTH (excess pixels) and before the first line_start after reset.
REQ-015 SHALL treat line_start and pixel_valid in the same cycle as a new line whose pixel 0 is that pixel.
REQ-016 SHALL push the assembled line into the FIFO on the cycle the pixel at index WIDTH-1 is accepted, including that pixel.
REQ-017 SHALL discard a partial line (index < WIDTH) on line_start without pushing.
REQ-018 SHALL deassert fifo_empty the cycle after the push (latency 1) when the FIFO was empty.
REQ-019 SHALL drive scanline combinationally from the head entry; value is don't-care while fifo_empty.
REQ-020 SHALL pop the head on fifo_ack while !fifo_empty; fifo_ack while fifo_empty is ignored.
REQ-021 SHALL accept a push when full only if fifo_ack is high the same cycle (simultaneous push+pop, count unchanged).
REQ-022 SHALL drop the line and set overflow when a push occurs while full with no fifo_ack; stored entries unchanged.
REQ-023 SHALL use pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ, low bits equal.
REQ-024 SHALL clear overflow only by reset.

Reset
REQ-025 SHALL on reset: pointers 0, fifo_empty 1, overflow 0, index WIDTH (idle, awaiting line_start), assembly register 0.
REQ-026 SHALL on reset mid-line or mid-FIFO discard all partial and buffered lines; no push occurs in the reset cycle.

Configuration
REQ-027 SHALL, with SCANLINE_PACKER_DROP_COUNT_EN defined, add output drop_count (16 bits, reset 0) incrementing per dropped line, saturating at 16'hFFFF.
REQ-028 SHALL, without SCANLINE_PACKER_DROP_COUNT_EN, omit drop_count entirely; all other behaviour identical.

Structure
REQ-029 SHALL take SCANLINE_WIDTH (160) and SCANLINE_BYTES (20) from shared package scanline_pkg, used as WIDTH default and by the downstream UART streamer.
REQ-030 SHALL place storage and pointer logic in one sub-module scanline_fifo (push, pop, din, dout, empty, full); packing logic stays in scanline_packer.

Verification
REQ-031 SHALL cover: line_start, 160 pixels alternating 1,0 -> fifo_empty falls 1 cycle after pixel 159; scanline = {80{2'b01}}.
REQ-032 SHALL cover: line_start, 100 pixels, line_start, 160 pixels all 1 -> exactly one entry, scanline = all ones.
REQ-033 SHALL cover: 5 full lines, no fifo_ack, DEPTH 4 -> 4 entries, line 5 dropped, overflow = 1, drop_count = 1 when enabled.
REQ-034 SHALL cover: FIFO full, 160th pixel coincident with fifo_ack -> push accepted, overflow stays 0, count stays 4.
REQ-035 SHALL cover: reset asserted at pixel 80 with 2 lines buffered -> fifo_empty = 1 immediately, following full line lands as sole entry.
REQ-036 SHALL cover: 200 pixels after line_start with pixel 159 = 1, pixels 160+ = 0 -> one push, bit 159 = 1, excess ignored.

Source files
------------

// File: rtl/scanline_pkg.sv
// Shared scanline geometry for the packer and the downstream UART streamer.
package scanline_pkg;

  localparam int SCANLINE_WIDTH = 160;
  localparam int SCANLINE_BYTES = SCANLINE_WIDTH / 8;

endpackage

// File: rtl/scanline_fifo.sv
// Scanline FIFO: DEPTH entries of WIDTH bits, wrap-bit pointers.
// A push while full is only taken when a pop happens in the same cycle;
// a pop while empty is ignored.
module scanline_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents for this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end
  end

  // Pointer and storage registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/scanline_packer.sv
// Scanline packer: assembles a serial pixel stream into WIDTH-bit scanlines
// and buffers completed lines in a small FIFO for a downstream consumer.
// Optional: define SCANLINE_PACKER_DROP_COUNT_EN to add a saturating
// 16-bit count of dropped lines on output drop_count.
module scanline_packer
  import scanline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SCANLINE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic             pixel_valid,
  input  logic             pixel,
  input  logic             fifo_ack,
  output logic             fifo_empty,
  output logic [WIDTH-1:0] scanline,
  output logic             overflow
`ifdef SCANLINE_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0]    IDX_IDLE = IW'(WIDTH);
  localparam logic [IW-1:0]    IDX_LAST = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             overflow_q, overflow_d;
  logic [IW-1:0]    start_idx;
  logic [WIDTH-1:0] start_asm;
  logic [WIDTH-1:0] bit_mask;
  logic             line_push;
  logic             line_drop;
  logic             fifo_full;

  // Pixel assembly: line_start restarts the line (and may carry pixel 0),
  // excess pixels are ignored, the last pixel completes and pushes the line.
  always_comb begin
    start_idx = line_start ? '0 : idx_q;
    start_asm = line_start ? '0 : asm_q;
    bit_mask  = ONE << start_idx;
    idx_d     = start_idx;
    asm_d     = start_asm;
    line_push = 1'b0;
    if (pixel_valid && (start_idx != IDX_IDLE)) begin
      asm_d = (start_asm & ~bit_mask) | ({WIDTH{pixel}} & bit_mask);
      idx_d = start_idx + IW'(1);
      if (start_idx == IDX_LAST) begin
        line_push = 1'b1;
      end
    end
  end

  assign line_drop = line_push && fifo_full && !fifo_ack;

  // Sticky overflow: set on any dropped line, cleared only by reset.
  always_comb begin
    overflow_d = overflow_q | line_drop;
  end

  // Assembly state registers; reset leaves the packer idle until line_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= IDX_IDLE;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  scanline_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (line_push),
    .pop   (fifo_ack),
    .din   (asm_d),
    .dout  (scanline),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef SCANLINE_PACKER_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  // Saturating count of dropped lines.
  always_comb begin
    drop_count_d = drop_count_q;
    if (line_drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_scanline_packer.sv
// Directed self-checking bench for scanline_packer (DEPTH 4, WIDTH 160).
// Expected scanlines are queued when a completing line is driven and popped
// when the bench acknowledges the FIFO head.
module tb_scanline_packer;
  import scanline_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = SCANLINE_WIDTH;

  logic             clk;
  logic             reset;
  logic             lineStart;
  logic             pixelValid;
  logic             pixel;
  logic             fifoAck;
  logic             fifoEmpty;
  logic [WIDTH-1:0] scanline;
  logic             overflow;
`ifdef SCANLINE_PACKER_DROP_COUNT_EN
  logic [15:0]      dropCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sbQ[$];

  scanline_packer #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (lineStart),
    .pixel_valid (pixelValid),
    .pixel       (pixel),
    .fifo_ack    (fifoAck),
    .fifo_empty  (fifoEmpty),
    .scanline    (scanline),
    .overflow    (overflow)
`ifdef SCANLINE_PACKER_DROP_COUNT_EN
    ,
    .drop_count  (dropCount)
`endif
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1. An ack with
  // an expected line queued compares the head before it is popped.
  task automatic applyStimulus(input logic start, input logic valid,
                               input logic pix, input logic ack);
    logic [WIDTH-1:0] exp;
    lineStart  = start;
    pixelValid = valid;
    pixel      = pix;
    fifoAck    = ack;
    if (ack && sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      checkOutput("head_not_empty", WIDTH'(fifoEmpty), '0);
      checkOutput("head_scanline", scanline, exp);
    end
    @(posedge clk);
    #1;
    lineStart  = 1'b0;
    pixelValid = 1'b0;
    pixel      = 1'b0;
    fifoAck    = 1'b0;
  endtask

  // line_start, then n pixels from bits; optional ack on the last pixel.
  task automatic sendLine(input logic [255:0] bits, input int n, input bit ackLast);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, bits[i], ackLast && (i == n - 1));
    end
  endtask

  // Pop every expected line, then confirm the FIFO is empty.
  task automatic drainAll(input string tag);
    int n;
    n = sbQ.size();
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput(tag, WIDTH'(fifoEmpty), WIDTH'(1));
  endtask

  function automatic logic [WIDTH-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0]     bits;
    logic [WIDTH-1:0] lines [5];

    reset      = 1'b1;
    lineStart  = 1'b0;
    pixelValid = 1'b0;
    pixel      = 1'b0;
    fifoAck    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_empty", WIDTH'(fifoEmpty), WIDTH'(1));
    checkOutput("reset_overflow", WIDTH'(overflow), '0);
`ifdef SCANLINE_PACKER_DROP_COUNT_EN
    checkOutput("reset_drop_count", WIDTH'(dropCount), '0);
`endif
    reset = 1'b0;

    $display("[TB] pixels before first line_start are ignored");
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("no_start_empty", WIDTH'(fifoEmpty), WIDTH'(1));

    $display("[TB] alternating line, push latency");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b0, 1'b1, ~i[0], 1'b0);
    checkOutput("alt_empty_before_last", WIDTH'(fifoEmpty), WIDTH'(1));
    sbQ.push_back({80{2'b01}});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("alt_empty_after_last", WIDTH'(fifoEmpty), '0);
    drainAll("alt_drained");

    $display("[TB] partial line discarded by line_start");
    sendLine({256{1'b0}}, 100, 1'b0);
    sbQ.push_back({WIDTH{1'b1}});
    sendLine({256{1'b1}}, WIDTH, 1'b0);
    drainAll("partial_single_entry");

    $display("[TB] line_start coincident with pixel 0");
    sendLine({256{1'b1}}, 50, 1'b0);
    bits = '0;
    bits[WIDTH-1:0] = randLine();
    bits[0] = 1'b1;
    sbQ.push_back(bits[WIDTH-1:0]);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < WIDTH; i++) applyStimulus(1'b0, 1'b1, bits[i], 1'b0);
    drainAll("coincident_drained");

    $display("[TB] excess pixels ignored");
    bits = '0;
    bits[WIDTH-1:0] = randLine();
    bits[WIDTH-1] = 1'b1;
    sbQ.push_back(bits[WIDTH-1:0]);
    sendLine(bits, 200, 1'b0);
    checkOutput("excess_not_empty", WIDTH'(fifoEmpty), '0);
    drainAll("excess_single_entry");

    $display("[TB] push while full with simultaneous ack");
    for (int k = 0; k < 5; k++) lines[k] = randLine();
    for (int k = 0; k < 4; k++) begin
      sbQ.push_back(lines[k]);
      sendLine({96'b0, lines[k]}, WIDTH, 1'b0);
    end
    checkOutput("full4_overflow", WIDTH'(overflow), '0);
    sbQ.push_back(lines[4]);
    sendLine({96'b0, lines[4]}, WIDTH, 1'b1);
    checkOutput("full_ack_overflow", WIDTH'(overflow), '0);
    drainAll("full_ack_count4");

    $display("[TB] push while full without ack drops the line");
    for (int k = 0; k < 5; k++) lines[k] = randLine();
    for (int k = 0; k < 4; k++) begin
      sbQ.push_back(lines[k]);
      sendLine({96'b0, lines[k]}, WIDTH, 1'b0);
    end
    sendLine({96'b0, lines[4]}, WIDTH, 1'b0);
    checkOutput("drop_overflow", WIDTH'(overflow), WIDTH'(1));
`ifdef SCANLINE_PACKER_DROP_COUNT_EN
    checkOutput("drop_count_one", WIDTH'(dropCount), WIDTH'(1));
`endif
    drainAll("drop_count4");
    checkOutput("overflow_sticky", WIDTH'(overflow), WIDTH'(1));

    $display("[TB] reset mid-line with lines buffered");
    for (int k = 0; k < 2; k++) begin
      lines[k] = randLine();
      sbQ.push_back(lines[k]);
      sendLine({96'b0, lines[k]}, WIDTH, 1'b0);
    end
    sendLine({256{1'b1}}, 80, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_empty", WIDTH'(fifoEmpty), WIDTH'(1));
    checkOutput("midreset_overflow", WIDTH'(overflow), '0);
    sbQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    lines[2] = randLine();
    sbQ.push_back(lines[2]);
    sendLine({96'b0, lines[2]}, WIDTH, 1'b0);
    checkOutput("postreset_not_empty", WIDTH'(fifoEmpty), '0);
    drainAll("postreset_single_entry");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
